// File: rtl/ir_queue.sv
// Instruction queue between fetch and decode: DEPTH-entry FIFO with valid/ready on both sides and a synchronous flush.
// Optional IR_QUEUE_BYPASS_EN lets a word offered to an empty queue reach decode in the same cycle.
module ir_queue #(
   parameter  int DWIDTH = 16,
   parameter  int DEPTH  = 4,
   localparam int AW     = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic [DWIDTH-1:0] ins,
   input  logic              ins_valid,
   output logic              ins_ready,
   output logic [DWIDTH-1:0] ir_out,
   output logic              ir_valid,
   input  logic              ir_ready,
   output logic [AW:0]       count,
   output logic              full,
   output logic              empty
);

   localparam logic [AW:0] PTR_ONE  = (AW+1)'(1);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   logic [DWIDTH-1:0] mem_q [DEPTH];
   logic [AW:0]       rptr_q, rptr_d;
   logic [AW:0]       wptr_q, wptr_d;
   logic [AW:0]       count_q, count_d;

   logic [DWIDTH-1:0] head;
   logic              push;
   logic              deq;
   logic              bypass_take;

   // Pointers carry an extra wrap bit so equal low bits can be told apart as full vs empty.
   assign empty     = (rptr_q == wptr_q);
   assign full      = (rptr_q[AW-1:0] == wptr_q[AW-1:0]) && (rptr_q[AW] != wptr_q[AW]);
   assign ins_ready = !full;
   assign count     = count_q;
   assign head      = mem_q[rptr_q[AW-1:0]];

`ifdef IR_QUEUE_BYPASS_EN
   logic bypass_vld;

   assign bypass_vld  = empty && ins_valid && !flush;
   assign ir_valid    = !empty || bypass_vld;
   assign ir_out      = !empty ? head : (bypass_vld ? ins : '0);
   assign bypass_take = bypass_vld && ir_ready;
`else
   assign ir_valid    = !empty;
   assign ir_out      = empty ? '0 : head;
   assign bypass_take = 1'b0;
`endif

   // A bypassed word is handed straight to decode, so neither pointer moves for it.
   assign deq  = ir_valid && ir_ready && !flush && !empty;
   assign push = ins_valid && ins_ready && !flush && !bypass_take;

   always_comb begin
      rptr_d  = rptr_q;
      wptr_d  = wptr_q;
      count_d = count_q;
      if (flush) begin
         rptr_d  = '0;
         wptr_d  = '0;
         count_d = '0;
      end else begin
         if (push) wptr_d = wptr_q + PTR_ONE;
         if (deq)  rptr_d = rptr_q + PTR_ONE;
         case ({push, deq})
            2'b10:   count_d = count_q + PTR_ONE;
            2'b01:   count_d = count_q - PTR_ONE;
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rptr_q  <= '0;
         wptr_q  <= '0;
         count_q <= '0;
      end else begin
         rptr_q  <= rptr_d;
         wptr_q  <= wptr_d;
         count_q <= count_d;
      end
   end

   // Array is deliberately not reset or cleared on flush; the pointers alone define validity.
   always_ff @(posedge clk) begin
      if (push) mem_q[wptr_q[AW-1:0]] <= ins;
   end

   a_count_tracks_ptrs: assert property (@(posedge clk) disable iff (rst)
      count_q == (wptr_q - rptr_q));
   a_count_bound: assert property (@(posedge clk) disable iff (rst)
      count_q <= FULL_CNT);
   a_full_matches_count: assert property (@(posedge clk) disable iff (rst)
      full == (count_q == FULL_CNT));

endmodule

// File: tb/tb_ir_queue.sv
// Directed self-checking bench for ir_queue (DEPTH=4, DWIDTH=16); bypass expectations follow IR_QUEUE_BYPASS_EN.
module tb_ir_queue;

   logic        clk = 1'b0;
   logic        rst;
   logic        flush;
   logic [15:0] ins;
   logic        ins_valid;
   logic        ins_ready;
   logic [15:0] ir_out;
   logic        ir_valid;
   logic        ir_ready;
   logic [2:0]  count;
   logic        full;
   logic        empty;

   int checks = 0;
   int errors = 0;

   ir_queue #(.DWIDTH(16), .DEPTH(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .ins       (ins),
      .ins_valid (ins_valid),
      .ins_ready (ins_ready),
      .ir_out    (ir_out),
      .ir_valid  (ir_valid),
      .ir_ready  (ir_ready),
      .count     (count),
      .full      (full),
      .empty     (empty)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   task automatic drive(input logic f, input logic v, input logic [15:0] d, input logic r);
      flush = f; ins_valid = v; ins = d; ir_ready = r;
   endtask

   task automatic idle;
      drive(1'b0, 1'b0, 16'h0000, 1'b0);
   endtask

   // Inputs change at the falling edge; results of the rising edge are observed at the next falling edge.
   task automatic tick;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic test_reset;
      rst = 1'b1;
      idle();
      @(negedge clk);
      checks++; if (count !== 3'd0)     begin errors++; $display("FAIL rst_count: got %0d expected 0", count); end
      checks++; if (empty !== 1'b1)     begin errors++; $display("FAIL rst_empty: got %b expected 1", empty); end
      checks++; if (full !== 1'b0)      begin errors++; $display("FAIL rst_full: got %b expected 0", full); end
      checks++; if (ins_ready !== 1'b1) begin errors++; $display("FAIL rst_ins_ready: got %b expected 1", ins_ready); end
      checks++; if (ir_valid !== 1'b0)  begin errors++; $display("FAIL rst_ir_valid: got %b expected 0", ir_valid); end
      checks++; if (ir_out !== 16'h0)   begin errors++; $display("FAIL rst_ir_out: got %h expected 0000", ir_out); end
      rst = 1'b0;
      tick();
      drive(1'b0, 1'b1, 16'h1111, 1'b0);
      tick();
      drive(1'b0, 1'b1, 16'h2222, 1'b0);
      tick();
      idle();
      checks++; if (count !== 3'd2)     begin errors++; $display("FAIL midrst_pre_count: got %0d expected 2", count); end
      #2 rst = 1'b1;
      #1;
      checks++; if (count !== 3'd0)     begin errors++; $display("FAIL midrst_count: got %0d expected 0", count); end
      checks++; if (empty !== 1'b1)     begin errors++; $display("FAIL midrst_empty: got %b expected 1", empty); end
      checks++; if (ir_valid !== 1'b0)  begin errors++; $display("FAIL midrst_ir_valid: got %b expected 0", ir_valid); end
      checks++; if (ir_out !== 16'h0)   begin errors++; $display("FAIL midrst_ir_out: got %h expected 0000", ir_out); end
      @(negedge clk);
      rst = 1'b0;
      drive(1'b0, 1'b1, 16'h3333, 1'b0);
      tick();
      idle();
      #1;
      checks++; if (ir_valid !== 1'b1)  begin errors++; $display("FAIL postrst_ir_valid: got %b expected 1", ir_valid); end
      checks++; if (ir_out !== 16'h3333) begin errors++; $display("FAIL postrst_ir_out: got %h expected 3333", ir_out); end
      checks++; if (count !== 3'd1)     begin errors++; $display("FAIL postrst_count: got %0d expected 1", count); end
      drive(1'b0, 1'b0, 16'h0000, 1'b1);
      tick();
      idle();
      checks++; if (empty !== 1'b1)     begin errors++; $display("FAIL postrst_drain: got empty=%b expected 1", empty); end
   endtask

   task automatic test_fill_drain;
      for (int i = 0; i < 4; i++) begin
         drive(1'b0, 1'b1, 16'hA000 + 16'(i), 1'b0);
         #1;
         checks++; if (ins_ready !== 1'b1) begin errors++; $display("FAIL fill_ready_%0d: got %b expected 1", i, ins_ready); end
         tick();
      end
      idle();
      checks++; if (full !== 1'b1)      begin errors++; $display("FAIL fill_full: got %b expected 1", full); end
      checks++; if (ins_ready !== 1'b0) begin errors++; $display("FAIL fill_ins_ready: got %b expected 0", ins_ready); end
      checks++; if (count !== 3'd4)     begin errors++; $display("FAIL fill_count: got %0d expected 4", count); end
      drive(1'b0, 1'b1, 16'hA004, 1'b0);
      tick();
      idle();
      checks++; if (count !== 3'd4)     begin errors++; $display("FAIL fifth_count: got %0d expected 4", count); end
      checks++; if (ir_out !== 16'hA000) begin errors++; $display("FAIL fifth_head: got %h expected a000", ir_out); end
      for (int i = 0; i < 4; i++) begin
         drive(1'b0, 1'b0, 16'h0000, 1'b1);
         #1;
         checks++; if (ir_valid !== 1'b1) begin errors++; $display("FAIL drain_valid_%0d: got %b expected 1", i, ir_valid); end
         checks++; if (ir_out !== 16'hA000 + 16'(i)) begin errors++; $display("FAIL drain_data_%0d: got %h expected %h", i, ir_out, 16'hA000 + 16'(i)); end
         tick();
      end
      idle();
      #1;
      checks++; if (empty !== 1'b1)    begin errors++; $display("FAIL drain_empty: got %b expected 1", empty); end
      checks++; if (ir_valid !== 1'b0) begin errors++; $display("FAIL drain_ir_valid: got %b expected 0", ir_valid); end
   endtask

   task automatic test_wrap;
      int pushed;
      int popped;
      pushed = 0;
      popped = 0;
      for (int i = 0; i < 40 && popped < 10; i++) begin
         drive(1'b0, pushed < 10, 16'(pushed), (i % 3) != 2);
         #1;
         if (ir_valid && ir_ready) begin
            checks++; if (ir_out !== 16'(popped)) begin errors++; $display("FAIL wrap_data_%0d: got %h expected %h", popped, ir_out, 16'(popped)); end
            popped++;
         end
         checks++; if (count > 3'd4) begin errors++; $display("FAIL wrap_count_%0d: got %0d expected <=4", i, count); end
         if (ins_valid && ins_ready) pushed++;
         tick();
      end
      idle();
      checks++; if (popped != 10)   begin errors++; $display("FAIL wrap_total: got %0d expected 10", popped); end
      checks++; if (empty !== 1'b1) begin errors++; $display("FAIL wrap_empty: got %b expected 1", empty); end
   endtask

   task automatic test_simul_push_pop;
      drive(1'b0, 1'b1, 16'hB001, 1'b0);
      tick();
      drive(1'b0, 1'b1, 16'hB002, 1'b0);
      tick();
      drive(1'b0, 1'b1, 16'hBEEF, 1'b1);
      #1;
      checks++; if (ir_out !== 16'hB001) begin errors++; $display("FAIL simul_head0: got %h expected b001", ir_out); end
      tick();
      idle();
      checks++; if (count !== 3'd2)      begin errors++; $display("FAIL simul_count: got %0d expected 2", count); end
      checks++; if (ir_out !== 16'hB002) begin errors++; $display("FAIL simul_head1: got %h expected b002", ir_out); end
      drive(1'b0, 1'b0, 16'h0000, 1'b1);
      tick();
      checks++; if (ir_out !== 16'hBEEF) begin errors++; $display("FAIL simul_beef: got %h expected beef", ir_out); end
      tick();
      idle();
      checks++; if (empty !== 1'b1)      begin errors++; $display("FAIL simul_empty: got %b expected 1", empty); end
   endtask

   task automatic test_flush;
      for (int i = 0; i < 3; i++) begin
         drive(1'b0, 1'b1, 16'hC000 + 16'(i), 1'b0);
         tick();
      end
      idle();
      checks++; if (count !== 3'd3)     begin errors++; $display("FAIL flush_pre_count: got %0d expected 3", count); end
      drive(1'b1, 1'b1, 16'hC0FF, 1'b1);
      tick();
      idle();
      #1;
      checks++; if (count !== 3'd0)     begin errors++; $display("FAIL flush_count: got %0d expected 0", count); end
      checks++; if (empty !== 1'b1)     begin errors++; $display("FAIL flush_empty: got %b expected 1", empty); end
      checks++; if (ir_valid !== 1'b0)  begin errors++; $display("FAIL flush_ir_valid: got %b expected 0", ir_valid); end
      checks++; if (ins_ready !== 1'b1) begin errors++; $display("FAIL flush_ins_ready: got %b expected 1", ins_ready); end
      drive(1'b0, 1'b1, 16'hD000, 1'b0);
      tick();
      idle();
      checks++; if (ir_out !== 16'hD000) begin errors++; $display("FAIL flush_next_word: got %h expected d000", ir_out); end
      checks++; if (count !== 3'd1)      begin errors++; $display("FAIL flush_next_count: got %0d expected 1", count); end
      drive(1'b0, 1'b0, 16'h0000, 1'b1);
      tick();
      idle();
      checks++; if (empty !== 1'b1)      begin errors++; $display("FAIL flush_final_empty: got %b expected 1", empty); end
   endtask

   task automatic test_bypass;
      drive(1'b0, 1'b1, 16'h5A5A, 1'b1);
      #1;
`ifdef IR_QUEUE_BYPASS_EN
      checks++; if (ir_valid !== 1'b1)   begin errors++; $display("FAIL byp_valid: got %b expected 1", ir_valid); end
      checks++; if (ir_out !== 16'h5A5A) begin errors++; $display("FAIL byp_data: got %h expected 5a5a", ir_out); end
      tick();
      idle();
      checks++; if (count !== 3'd0)      begin errors++; $display("FAIL byp_count: got %0d expected 0", count); end
      checks++; if (empty !== 1'b1)      begin errors++; $display("FAIL byp_empty: got %b expected 1", empty); end
`else
      checks++; if (ir_valid !== 1'b0)   begin errors++; $display("FAIL nobyp_valid0: got %b expected 0", ir_valid); end
      checks++; if (ir_out !== 16'h0)    begin errors++; $display("FAIL nobyp_data0: got %h expected 0000", ir_out); end
      tick();
      idle();
      #1;
      checks++; if (ir_valid !== 1'b1)   begin errors++; $display("FAIL nobyp_valid1: got %b expected 1", ir_valid); end
      checks++; if (ir_out !== 16'h5A5A) begin errors++; $display("FAIL nobyp_data1: got %h expected 5a5a", ir_out); end
      checks++; if (count !== 3'd1)      begin errors++; $display("FAIL nobyp_count: got %0d expected 1", count); end
      drive(1'b0, 1'b0, 16'h0000, 1'b1);
      tick();
      idle();
      checks++; if (empty !== 1'b1)      begin errors++; $display("FAIL nobyp_empty: got %b expected 1", empty); end
`endif
   endtask

   initial begin
      test_reset();
      test_fill_drain();
      test_wrap();
      test_simul_push_pop();
      test_flush();
      test_bypass();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
